// File: rtl/video_pkg.sv
// Shared types and helpers for the video source switch: pixel struct, selector state, latency unpacking.
package video_pkg;

    localparam int RGB_COLOR_W = 8;

    typedef struct packed {
        logic [RGB_COLOR_W-1:0] r;
        logic [RGB_COLOR_W-1:0] g;
        logic [RGB_COLOR_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        GUARD
    } sel_state_t;

    // Pull entry idx out of a packed latency table whose entries are lat_w bits wide.
    function automatic int lat_entry(input logic [63:0] packed_lat, input int idx, input int lat_w);
        logic [63:0] mask;
        mask = (64'd1 << lat_w) - 64'd1;
        return int'((packed_lat >> (idx * lat_w)) & mask);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Shift register for the sync bundle; tap k returns the input delayed by k cycles (tap 0 = input).
module sync_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] din,
    input  logic [SEL_W-1:0] tap_sel,
    output logic [WIDTH-1:0] tap_out
);

    logic [WIDTH-1:0] stage_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_reg[k] <= '0;
            end
        end else begin
            stage_reg[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                stage_reg[k] <= stage_reg[k-1];
            end
        end
    end

    // Tap selects beyond DEPTH fall back to the undelayed input.
    always_comb begin
        tap_out = din;
        for (int k = 1; k <= DEPTH; k++) begin
            if (int'(tap_sel) == k) begin
                tap_out = stage_reg[k-1];
            end
        end
    end

endmodule

// File: rtl/video_source_switch.sv
// Frame-synchronous N-way video source selector: realigns hs/vs/ad to the active source's latency
// and blanks video for a guard window after every committed switch.
module video_source_switch
    import video_pkg::*;
#(
    parameter int                         NUM_SRC     = 4,
    parameter int                         COLOR_W     = 8,
    parameter int                         MAX_LAT     = 8,
    parameter int                         LAT_W       = 4,
    parameter logic [NUM_SRC*LAT_W-1:0]   SRC_LAT     = 16'h5533,
    parameter int                         DEFAULT_SRC = 0
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           hs_in,
    input  logic                           vs_in,
    input  logic                           ad_in,
    input  logic                           nf_in,
    input  logic [NUM_SRC*3*COLOR_W-1:0]   src_rgb_in,
    input  logic [$clog2(NUM_SRC)-1:0]     sel_in,
    input  logic                           fill_en_in,
    input  logic [3*COLOR_W-1:0]           fill_rgb_in,
    output logic [COLOR_W-1:0]             red_out,
    output logic [COLOR_W-1:0]             green_out,
    output logic [COLOR_W-1:0]             blue_out,
    output logic                           hs_out,
    output logic                           vs_out,
    output logic                           ad_out,
    output logic [$clog2(NUM_SRC)-1:0]     active_sel_out,
    output logic                           pending_out
);

    localparam int SEL_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(MAX_LAT + 2);
    localparam int PIX_W = 3 * COLOR_W;

    sel_state_t        state_reg, state_next;
    logic [SEL_W-1:0]  active_reg, active_next;
    logic [SEL_W-1:0]  target_reg, target_next;
    logic              pending_reg, pending_next;
    logic [CNT_W-1:0]  guard_cnt_reg, guard_cnt_next;

    logic [LAT_W-1:0]  lat_tab [NUM_SRC];
    logic [PIX_W-1:0]  src_pix [NUM_SRC];
    logic [2:0]        sync_tap;
    logic              sel_valid;
    logic              blank;

    logic [PIX_W-1:0]  rgb_reg;
    logic              hs_reg, vs_reg, ad_reg;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            localparam int LAT_I = lat_entry(64'(SRC_LAT), gi, LAT_W);
            if (LAT_I > MAX_LAT) begin : g_lat_err
                $error("video_source_switch: SRC_LAT entry %0d (%0d) exceeds MAX_LAT %0d", gi, LAT_I, MAX_LAT);
            end
            assign lat_tab[gi] = LAT_W'(LAT_I);
            assign src_pix[gi] = src_rgb_in[gi*PIX_W +: PIX_W];
        end
        if (DEFAULT_SRC >= NUM_SRC) begin : g_def_err
            $error("video_source_switch: DEFAULT_SRC %0d out of range", DEFAULT_SRC);
        end
    endgenerate

    assign sel_valid = int'(sel_in) < NUM_SRC;

    always_comb begin
        state_next     = state_reg;
        active_next    = active_reg;
        target_next    = target_reg;
        pending_next   = pending_reg;
        guard_cnt_next = guard_cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (sel_valid && sel_in != active_reg) begin
                    state_next   = PENDING;
                    target_next  = sel_in;
                    pending_next = 1'b1;
                end
            end
            PENDING: begin
                if (sel_valid && sel_in == active_reg) begin
                    state_next   = IDLE;
                    pending_next = 1'b0;
                end else begin
                    if (sel_valid) begin
                        target_next = sel_in;
                    end
                    // Commit uses the request registered before this cycle.
                    if (nf_in) begin
                        active_next    = target_reg;
                        guard_cnt_next = CNT_W'(MAX_LAT + 1);
                        pending_next   = 1'b0;
                        state_next     = GUARD;
                    end
                end
            end
            GUARD: begin
                guard_cnt_next = guard_cnt_reg - CNT_W'(1);
                if (sel_valid) begin
                    pending_next = (sel_in != active_reg);
                    if (sel_in != active_reg) begin
                        target_next = sel_in;
                    end
                end
                if (guard_cnt_reg == CNT_W'(1)) begin
                    state_next = pending_next ? PENDING : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg     <= IDLE;
            active_reg    <= SEL_W'(DEFAULT_SRC);
            target_reg    <= SEL_W'(DEFAULT_SRC);
            pending_reg   <= 1'b0;
            guard_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            active_reg    <= active_next;
            target_reg    <= target_next;
            pending_reg   <= pending_next;
            guard_cnt_reg <= guard_cnt_next;
        end
    end

    // Output stage looks at the source that will be active after this edge, so the
    // commit edge already loads the new tap and the blanking lines up with GUARD.
    sync_delay_line #(
        .WIDTH (3),
        .DEPTH (MAX_LAT),
        .SEL_W (LAT_W)
    ) u_sync_delay (
        .clk     (clk_in),
        .srst    (rst_in),
        .din     ({hs_in, vs_in, ad_in}),
        .tap_sel (lat_tab[active_next]),
        .tap_out (sync_tap)
    );

    assign blank = (state_next == GUARD);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hs_reg  <= 1'b0;
            vs_reg  <= 1'b0;
            ad_reg  <= 1'b0;
            rgb_reg <= '0;
        end else begin
            hs_reg <= sync_tap[2];
            vs_reg <= sync_tap[1];
            ad_reg <= sync_tap[0] && !blank;
            if (blank || !sync_tap[0]) begin
                rgb_reg <= '0;
            end else if (fill_en_in) begin
                rgb_reg <= fill_rgb_in;
            end else begin
                rgb_reg <= src_pix[active_next];
            end
        end
    end

    assign red_out        = rgb_reg[PIX_W-1 -: COLOR_W];
    assign green_out      = rgb_reg[2*COLOR_W-1 -: COLOR_W];
    assign blue_out       = rgb_reg[COLOR_W-1:0];
    assign hs_out         = hs_reg;
    assign vs_out         = vs_reg;
    assign ad_out         = ad_reg;
    assign active_sel_out = active_reg;
    assign pending_out    = pending_reg;

endmodule
